stat_nclus_hist: RTL and testbench
==================================

// Module: stat_nclus_hist
// PURPOSE
//  Parametrised cluster-multiplicity histogram; successor to the fixed 10-bin nclus counter.
//  Counts accepted L1 triggers per nclus bin during a live (spill) window.
//  Freezes a snapshot bank at the end of each spill.
//  The snapshot is read by register readout, one bin per request, while the next spill accumulates.
//  Sits beside the top CDT trigger logic; fed by the same lv1b_req, nclus and scaled-intensity signals.
// PARAMETERS
//  NBINS    10  number of bins; bins 0..NBINS-2 are direct, bin NBINS-1 is the overflow bin
//  CNT_W    16  width of each bin counter
//  NCLUS_W  4   width of in_nclus
//  INT_W    8   width of in_int_scaled
//  AW       $clog2(NBINS)  readout address width (derived, localparam)
// PORTS
//  clk            in   1              system clock
//  rst_n          in   1              asynchronous, active-low reset
//  in_live        in   1              live/spill gate; rising edge = spill start, falling edge = spill end
//  in_int_scaled  in   INT_W          scaled intensity; trigger counted only if nonzero
//  in_nclus       in   NCLUS_W        cluster multiplicity of current trigger
//  lv1b_req       in   1              L1b accept strobe, one cycle per trigger
//  rd_en          in   1              readout request
//  rd_addr        in   AW             bin index to read from snapshot bank
//  rd_data        out  CNT_W          snapshot bin value
//  rd_valid       out  1              one-cycle pulse qualifying rd_data
//  snap_valid     out  1              high once at least one snapshot has been taken
//  total_cnt      out  CNT_W+AW       live count of all accepted triggers
//  live_bus       out  NBINS*CNT_W    live bin values, bin i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - All live bins, snapshot bins, total_cnt, rd_data, rd_valid, snap_valid and the pre_live register go to 0.
//  Edge detect
//   - pre_live is a register of in_live.
//   - Spill start: in_live=1 and pre_live=0.
//   - Spill end: in_live=0 and pre_live=1.
//  Accept
//   - acc = lv1b_req & (in_int_scaled!=0). Counting is not gated by in_live.
//   - Bin select: in_nclus < NBINS-1 gives bin in_nclus; otherwise bin NBINS-1.
//  Spill start
//   - Live bins and total_cnt clear.
//   - An accept in the same cycle lands after the clear: selected bin = 1, total_cnt = 1.
//   - The snapshot bank is untouched.
//  Increment
//   - The selected bin and total_cnt increment by 1 on the clock edge after the acc cycle.
//   - Latency 1 cycle.
//  Width
//   - Counters wrap modulo 2^CNT_W (total_cnt modulo 2^(CNT_W+AW)) unless saturation is compiled in.
//  Spill end
//   - Snapshot bank loads the live bins' next-state values, including any same-cycle accept.
//   - snap_valid sets to 1 and stays set until reset.
//   - Live bins keep counting after spill end; they clear only at the next spill start.
//  Readout
//   - rd_en sampled at edge N; rd_data and rd_valid (=1) appear after edge N. rd_valid is 1 cycle wide.
//   - rd_addr >= NBINS returns rd_data = 0 with rd_valid = 1.
//   - Back-to-back rd_en every cycle is supported.
//   - A read sampled on the same edge as a snapshot load returns the pre-load value.
//   - rd_data holds its value between reads.
// CONFIGURATION
//  STAT_NCLUS_SATURATE_EN defined
//   - Bin counters and total_cnt saturate at all-ones instead of wrapping.
//   - Adds output ovf_flags [NBINS]: bit i is sticky and sets when bin i is held at max by an accept.
//   - ovf_flags clears at spill start and at reset.
//  STAT_NCLUS_SATURATE_EN undefined
//   - Counters wrap. ovf_flags does not exist.
// STRUCTURE
//  Package stat_nclus_pkg
//   - Default CNT_W, NBINS, NCLUS_W and INT_W constants.
//   - Bin-select function.
//   - Localparam for the overflow-bin index.
//  Sub-module stat_bin_counter, generated NBINS times
//   - Inputs: clr, inc.
//   - Outputs: cnt and nxt (next-state value, used for the snapshot load); ovf when saturation is compiled in.
//  Top level
//   - Edge detect, bin decode, snapshot bank, readout mux/register, total counter.
// TESTING
//  T1 Reset
//   - rst_n low mid-spill with bins nonzero -> all outputs 0 in the same cycle.
//   - snap_valid = 0 after release.
//  T2 Binning
//   - Spill start, then 3 accepts each with nclus = 0, 2, 8, 9, 15 (NBINS=10), in_int_scaled = 5.
//   - Expect bins 0, 2, 8 = 3, bin 9 = 6, total_cnt = 15.
//   - An accept with in_int_scaled = 0 adds nothing.
//  T3 Same-cycle clear and accept
//   - Spill start coincident with an accept at nclus = 1 -> bin1 = 1, all other bins 0.
//  T4 Snapshot
//   - Spill end coincident with an accept at nclus = 4 (bin4 was 6) -> read addr 4 gives 7, snap_valid = 1.
//   - Next spill accumulates; snapshot reads are unchanged.
//   - Read addr 12 -> rd_data = 0, rd_valid = 1.
//  T5 Readout timing
//   - rd_en held for 10 cycles, addr 0..9 -> 10 consecutive rd_valid pulses, 1-cycle latency, data in order.
//  T6 Width limit, CNT_W = 4
//   - 17 accepts into bin 3 -> bin3 = 1 without the macro.
//   - With STAT_NCLUS_SATURATE_EN: bin3 = 15 and ovf_flags[3] = 1; the next spill start clears both.

Source files
------------

// File: rtl/stat_nclus_pkg.sv
// Shared constants and bin-select helper for the nclus multiplicity histogram.
package stat_nclus_pkg;

    localparam int unsigned NBINS_DEF   = 10;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned NCLUS_W_DEF = 4;
    localparam int unsigned INT_W_DEF   = 8;
    localparam int unsigned OVF_BIN_DEF = NBINS_DEF - 1;

    // Direct bins below the overflow index; everything else lands in the overflow bin.
    function automatic int unsigned bin_sel(input int unsigned nclus,
                                            input int unsigned ovf_bin = OVF_BIN_DEF);
        return (nclus < ovf_bin) ? nclus : ovf_bin;
    endfunction

endpackage

// File: rtl/stat_nclus_hist_if.sv
// Trigger-input and snapshot-readout signals of stat_nclus_hist.
interface stat_nclus_hist_if #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned NCLUS_W = 4,
    parameter int unsigned INT_W   = 8,
    parameter int unsigned AW      = 4
);
    logic               in_live;
    logic [INT_W-1:0]   in_int_scaled;
    logic [NCLUS_W-1:0] in_nclus;
    logic               lv1b_req;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [CNT_W-1:0]   rd_data;
    logic               rd_valid;

    modport master (
        output in_live, in_int_scaled, in_nclus, lv1b_req, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  in_live, in_int_scaled, in_nclus, lv1b_req, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/stat_bin_counter.sv
// Single histogram bin: clear-then-increment counter exposing its next-state value.
// STAT_NCLUS_SATURATE_EN: saturate at all-ones and add a sticky ovf flag.
module stat_bin_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] nxt
`ifdef STAT_NCLUS_SATURATE_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A clear and an accept in the same cycle leave the bin at 1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? CNT_W'(1) : '0;
        end else if (inc) begin
`ifdef STAT_NCLUS_SATURATE_EN
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
`else
            cnt_d = cnt_q + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign nxt = cnt_d;

`ifdef STAT_NCLUS_SATURATE_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (clr)                            ovf_d = 1'b0;
        else if (inc && (cnt_q == CNT_MAX)) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    localparam logic UNUSED_MAX = &CNT_MAX;
`endif

endmodule

// File: rtl/stat_nclus_hist.sv
// Cluster-multiplicity histogram with per-spill snapshot bank and register readout.
// STAT_NCLUS_SATURATE_EN: saturating counters plus sticky ovf_flags output.
module stat_nclus_hist
    import stat_nclus_pkg::*;
#(
    parameter int unsigned NBINS   = NBINS_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned NCLUS_W = NCLUS_W_DEF,
    parameter int unsigned INT_W   = INT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    stat_nclus_hist_if.slave          bus,
`ifdef STAT_NCLUS_SATURATE_EN
    output logic [NBINS-1:0]          ovf_flags,
`endif
    output logic                      snap_valid,
    output logic [CNT_W+$clog2(NBINS)-1:0] total_cnt,
    output logic [NBINS*CNT_W-1:0]    live_bus
);

    localparam int unsigned AW      = $clog2(NBINS);
    localparam int unsigned TOT_W   = CNT_W + AW;
    localparam int unsigned OVF_BIN = NBINS - 1;
    localparam logic [AW:0] NBINS_A = (AW+1)'(NBINS);

    logic             pre_live_q;
    logic             spill_start_c, spill_end_c, acc_c;
    logic [AW-1:0]    sel_c;
    logic [CNT_W-1:0] cnt [NBINS];
    logic [CNT_W-1:0] nxt [NBINS];
    logic [CNT_W-1:0] snap_q [NBINS];
    logic [CNT_W-1:0] snap_d [NBINS];
    logic             snap_valid_q, snap_valid_d;
    logic [TOT_W-1:0] tot_q, tot_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    assign spill_start_c = bus.in_live & ~pre_live_q;
    assign spill_end_c   = ~bus.in_live & pre_live_q;
    assign acc_c         = bus.lv1b_req & (bus.in_int_scaled != '0);
    assign sel_c         = AW'(bin_sel(32'(bus.in_nclus), OVF_BIN));

    for (genvar g = 0; g < NBINS; g++) begin : g_bin
        stat_bin_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (spill_start_c),
            .inc   (acc_c && (sel_c == AW'(g))),
            .cnt   (cnt[g]),
            .nxt   (nxt[g])
`ifdef STAT_NCLUS_SATURATE_EN
            ,
            .ovf   (ovf_flags[g])
`endif
        );
        assign live_bus[g*CNT_W +: CNT_W] = cnt[g];
    end

    // Total counter mirrors the bin clear/increment rules at the wider width.
    always_comb begin
        tot_d = tot_q;
        if (spill_start_c) begin
            tot_d = acc_c ? TOT_W'(1) : '0;
        end else if (acc_c) begin
`ifdef STAT_NCLUS_SATURATE_EN
            if (tot_q != '1) tot_d = tot_q + TOT_W'(1);
`else
            tot_d = tot_q + TOT_W'(1);
`endif
        end
    end

    // Snapshot captures next-state bins so a spill-end accept is included.
    always_comb begin
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q | spill_end_c;
        if (spill_end_c) snap_d = nxt;
    end

    // Reads see the bank as it stood before this edge's load.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = bus.rd_en;
        if (bus.rd_en) begin
            rd_data_d = ({1'b0, bus.rd_addr} < NBINS_A) ? snap_q[bus.rd_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_live_q   <= 1'b0;
            snap_q       <= '{default: '0};
            snap_valid_q <= 1'b0;
            tot_q        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            pre_live_q   <= bus.in_live;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            tot_q        <= tot_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign snap_valid   = snap_valid_q;
    assign total_cnt    = tot_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_stat_nclus_hist.sv
// Scoreboard bench for stat_nclus_hist: 16-bit instance for T1-T5, 4-bit instance for T6.
module tb_stat_nclus_hist;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stat_nclus_hist_if #(.CNT_W(16), .NCLUS_W(4), .INT_W(8), .AW(4)) a_if ();
    stat_nclus_hist_if #(.CNT_W(4),  .NCLUS_W(4), .INT_W(8), .AW(4)) b_if ();

    logic        a_snap_valid, b_snap_valid;
    logic [19:0] a_total;
    logic [7:0]  b_total;
    logic [159:0] a_live;
    logic [39:0]  b_live;
`ifdef STAT_NCLUS_SATURATE_EN
    logic [9:0] a_ovf, b_ovf;
`endif

    stat_nclus_hist #(.NBINS(10), .CNT_W(16), .NCLUS_W(4), .INT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if),
`ifdef STAT_NCLUS_SATURATE_EN
        .ovf_flags(a_ovf),
`endif
        .snap_valid(a_snap_valid), .total_cnt(a_total), .live_bus(a_live));

    stat_nclus_hist #(.NBINS(10), .CNT_W(4), .NCLUS_W(4), .INT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if),
`ifdef STAT_NCLUS_SATURATE_EN
        .ovf_flags(b_ovf),
`endif
        .snap_valid(b_snap_valid), .total_cnt(b_total), .live_bus(b_live));

    typedef struct {
        logic [15:0] data;
        int unsigned due;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    int unsigned eb[10];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] pack_a();
        logic [159:0] v = '0;
        for (int i = 0; i < 10; i++) v[i*16 +: 16] = 16'(eb[i]);
        return v;
    endfunction

    task automatic clr_eb();
        for (int i = 0; i < 10; i++) eb[i] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_a(input int nclus, input int intv);
        a_if.lv1b_req      = 1'b1;
        a_if.in_nclus      = 4'(nclus);
        a_if.in_int_scaled = 8'(intv);
        tick();
        a_if.lv1b_req      = 1'b0;
    endtask

    // Issues one read; caller deasserts rd_en when the burst ends.
    task automatic rd_issue(input int addr, input int exp);
        a_if.rd_en   = 1'b1;
        a_if.rd_addr = 4'(addr);
        sb_q.push_back('{16'(exp), cyc + 1});
        tick();
    endtask

    task automatic rd_one(input int addr, input int exp);
        rd_issue(addr, exp);
        a_if.rd_en = 1'b0;
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected read and its due cycle.
    always @(negedge clk) begin : mon
        rd_exp_t e;
        if (a_if.rd_valid === 1'b1) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got data=%h at cyc=%0d want no pulse", a_if.rd_data, cyc);
            end else begin
                e = sb_q.pop_front();
                if (a_if.rd_data !== e.data || cyc != e.due) begin
                    n_err++;
                    $display("FAIL rd_data: got=%h cyc=%0d want=%h cyc=%0d",
                             a_if.rd_data, cyc, e.data, e.due);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        a_if.in_live = 0; a_if.in_int_scaled = 0; a_if.in_nclus = 0; a_if.lv1b_req = 0;
        a_if.rd_en = 0; a_if.rd_addr = 0;
        b_if.in_live = 0; b_if.in_int_scaled = 0; b_if.in_nclus = 0; b_if.lv1b_req = 0;
        b_if.rd_en = 0; b_if.rd_addr = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_total", 160'(a_total), '0);
        chk("rst_live", a_live, '0);
        chk("rst_snap_valid", 160'(a_snap_valid), '0);
        chk("rst_rd", {a_if.rd_valid, a_if.rd_data}, '0);

        // T1: fill a snapshot, start a spill, reset asynchronously mid-spill
        a_if.in_live = 1; tick();
        repeat (3) acc_a(5, 5);
        a_if.in_live = 0; tick();
        rd_one(5, 3);
        a_if.in_live = 1; tick();
        repeat (2) acc_a(7, 5);
        tick();
        chk("t1_pre_total", 160'(a_total), 160'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_total", 160'(a_total), '0);
        chk("t1_async_live", a_live, '0);
        chk("t1_async_snap_valid", 160'(a_snap_valid), '0);
        chk("t1_async_rd_data", 160'(a_if.rd_data), '0);
        tick();
        a_if.in_live = 0;
        rst_n = 1'b1;
        repeat (2) tick();
        chk("t1_post_snap_valid", 160'(a_snap_valid), '0);

        // T2: binning incl. overflow bin and zero-intensity reject
        a_if.in_live = 1; tick();
        foreach (eb[i]) eb[i] = 0;
        for (int k = 0; k < 5; k++) begin
            int nc;
            nc = (k == 0) ? 0 : (k == 1) ? 2 : (k == 2) ? 8 : (k == 3) ? 9 : 15;
            repeat (3) acc_a(nc, 5);
        end
        acc_a(3, 0);
        clr_eb(); eb[0] = 3; eb[2] = 3; eb[8] = 3; eb[9] = 6;
        chk("t2_live", a_live, pack_a());
        chk("t2_total", 160'(a_total), 160'(15));

        // T3: spill end, then spill start coincident with accept
        a_if.in_live = 0; tick();
        a_if.in_live = 1; acc_a(1, 5);
        clr_eb(); eb[1] = 1;
        chk("t3_live", a_live, pack_a());
        chk("t3_total", 160'(a_total), 160'(1));
        rd_one(9, 6);
        rd_one(3, 0);
        rd_one(0, 3);

        // T4: spill end coincident with accept and a read of the pre-load value
        repeat (6) acc_a(4, 5);
        a_if.in_live = 0;
        a_if.rd_en = 1; a_if.rd_addr = 4'd4;
        sb_q.push_back('{16'd0, cyc + 1});
        acc_a(4, 5);
        a_if.rd_en = 0;
        clr_eb(); eb[1] = 1; eb[4] = 7;
        chk("t4_live_after_end", a_live, pack_a());
        chk("t4_total", 160'(a_total), 160'(8));
        chk("t4_snap_valid", 160'(a_snap_valid), 160'(1));
        rd_one(4, 7);
        rd_one(1, 1);
        a_if.in_live = 1; tick();
        repeat (2) acc_a(4, 5);
        clr_eb(); eb[4] = 2;
        chk("t4_next_spill_live", a_live, pack_a());
        rd_one(4, 7);
        rd_one(12, 0);
        rd_one(4, 7);
        repeat (2) tick();
        chk("t4_rd_hold", {a_if.rd_valid, a_if.rd_data}, 160'(17'h00007));

        // T5: back-to-back reads over all bins
        for (int i = 0; i < 10; i++) rd_issue(i, (i == 1) ? 1 : (i == 4) ? 7 : 0);
        a_if.rd_en = 0;
        repeat (3) tick();
        chk("t5_sb_drained", 160'(sb_q.size()), '0);

        // T6: 4-bit width limit on the second instance
        b_if.in_live = 1; tick();
        b_if.lv1b_req = 1; b_if.in_nclus = 4'd3; b_if.in_int_scaled = 8'd1;
        repeat (17) tick();
        b_if.lv1b_req = 0;
`ifdef STAT_NCLUS_SATURATE_EN
        chk("t6_bin3_sat", 160'(b_live[12 +: 4]), 160'(15));
        chk("t6_ovf", 160'(b_ovf), 160'(10'b0000001000));
`else
        chk("t6_bin3_wrap", 160'(b_live[12 +: 4]), 160'(1));
`endif
        chk("t6_total", 160'(b_total), 160'(17));
        b_if.in_live = 0; tick();
        b_if.in_live = 1; tick();
        chk("t6_clear_live", 160'(b_live), '0);
`ifdef STAT_NCLUS_SATURATE_EN
        chk("t6_clear_ovf", 160'(b_ovf), '0);
`endif
        chk("t6_b_rd_idle", 160'(b_if.rd_valid), '0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
